// File: rtl/sprite_compositor.sv
// Single-sprite pixel source for the VGA timing generator: turns look-ahead coordinates into an RGB222
// pixel one cycle later, with colour-key transparency and tear-free position updates at vertical blanking.
module sprite_compositor #(
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter int          H_ACTIVE  = 800,
    parameter int          V_ACTIVE  = 600,
    parameter logic [5:0]  BG_COLOR  = 6'b000110,
    parameter logic [5:0]  KEY_COLOR = 6'b110011
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [10:0]                       nextH,
    input  logic [9:0]                        nextV,
    input  logic                              nextActive,
    output logic [5:0]                        pixel,
    input  logic [10:0]                       pos_x,
    input  logic [9:0]                        pos_y,
    input  logic                              pos_valid,
    output logic                              pos_ready,
    output logic [$clog2(SPR_W*SPR_H)-1:0]    spr_addr,
    input  logic [5:0]                        spr_data,
    output logic                              frame_tick
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    logic [10:0]   act_x_q, act_x_d;
    logic [9:0]    act_y_q, act_y_d;
    logic [10:0]   shd_x_q, shd_x_d;
    logic [9:0]    shd_y_q, shd_y_d;
    logic          pend_q, pend_d;
    logic          in_spr_q, in_spr_d;
    logic          vis_q, vis_d;
    logic          tick_q, tick_d;

    logic          apply_s;
    logic          accept_s;
    logic          in_spr_s;
    logic [11:0]   x_end_s;
    logic [10:0]   y_end_s;
    logic [CW-1:0] dh_s;
    logic [RW-1:0] dv_s;

    // Extended-width sprite extents so a sprite at the screen edge cannot wrap the compare.
    assign x_end_s  = {1'b0, act_x_q} + 12'(SPR_W);
    assign y_end_s  = {1'b0, act_y_q} + 11'(SPR_H);
    assign in_spr_s = nextActive
                    & (nextH >= act_x_q) & ({1'b0, nextH} < x_end_s)
                    & (nextV >= act_y_q) & ({1'b0, nextV} < y_end_s);

    // Only the low bits of the offsets address the ROM, so the subtraction is done at that width.
    assign dh_s     = nextH[CW-1:0] - act_x_q[CW-1:0];
    assign dv_s     = nextV[RW-1:0] - act_y_q[RW-1:0];
    assign spr_addr = {dv_s, dh_s};

    assign apply_s    = en & (nextH == 11'd0) & (nextV == 10'(V_ACTIVE));
    assign accept_s   = pos_valid & ~pend_q;
    assign pos_ready  = ~pend_q;
    assign frame_tick = tick_q;

    // Next-state: shadow capture, blanking-time apply, and per-pixel flags.
    always_comb begin
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        shd_x_d  = shd_x_q;
        shd_y_d  = shd_y_q;
        pend_d   = pend_q;
        in_spr_d = in_spr_q;
        vis_d    = vis_q;
        tick_d   = 1'b0;
        if (apply_s && pend_q) begin
            act_x_d = shd_x_q;
            act_y_d = shd_y_q;
            pend_d  = 1'b0;
            tick_d  = 1'b1;
        end else if (accept_s) begin
            shd_x_d = pos_x;
            shd_y_d = pos_y;
            pend_d  = 1'b1;
        end else begin
            pend_d  = pend_q;
        end
        if (en) begin
            in_spr_d = in_spr_s;
            vis_d    = nextActive;
        end else begin
            in_spr_d = in_spr_q;
            vis_d    = vis_q;
        end
    end

    // State register with synchronous active-low reset parking the sprite off-screen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_x_q  <= 11'(H_ACTIVE);
            act_y_q  <= 10'(V_ACTIVE);
            shd_x_q  <= 11'd0;
            shd_y_q  <= 10'd0;
            pend_q   <= 1'b0;
            in_spr_q <= 1'b0;
            vis_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            shd_x_q  <= shd_x_d;
            shd_y_q  <= shd_y_d;
            pend_q   <= pend_d;
            in_spr_q <= in_spr_d;
            vis_q    <= vis_d;
            tick_q   <= tick_d;
        end
    end

    // Output mux; spr_data arrives this cycle from the ROM read issued last cycle.
    always_comb begin
        pixel = 6'd0;
        if (!vis_q) begin
            pixel = 6'd0;
        end else if (in_spr_q && (spr_data != KEY_COLOR)) begin
            pixel = spr_data;
        end else begin
            pixel = BG_COLOR;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: drives look-ahead coordinates directly and checks pixel,
// handshake and frame_tick against hand-computed values from a 1-cycle ROM model.
module tb_sprite_compositor;

    localparam logic [5:0] BG  = 6'b000110;
    localparam logic [5:0] KEY = 6'b110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] nextH;
    logic [9:0]  nextV;
    logic        nextActive;
    logic [5:0]  pixel;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic        pos_valid;
    logic        pos_ready;
    logic [9:0]  spr_addr;
    logic [5:0]  spr_data;
    logic        frame_tick;

    logic [5:0]  rom [0:1023];
    int          checks = 0;
    int          errors = 0;

    sprite_compositor dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .nextH      (nextH),
        .nextV      (nextV),
        .nextActive (nextActive),
        .pixel      (pixel),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // ROM shares the pixel enable so its data stays aligned with the held coordinate.
    always @(posedge clk) begin
        if (en) spr_data <= rom[spr_addr];
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [10:0] h, input logic [9:0] v, input logic a);
        @(negedge clk);
        nextH = h; nextV = v; nextActive = a; en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic a);
        present(h, v, a);
        tick();
    endtask

    task automatic send_req(input logic [10:0] x, input logic [9:0] y, input logic exp_ready);
        @(negedge clk);
        pos_x = x; pos_y = y; pos_valid = 1'b1;
        #1 chk("ready_req", pos_ready, exp_ready);
        tick();
        pos_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [5:0] v;
            v = 6'(i) + 6'd1;
            if (v == KEY || v == BG) v = 6'h2A;
            rom[i] = v;
        end
        rom[5] = KEY;

        rst = 1'b0; en = 1'b1; nextH = 11'd0; nextV = 10'd0; nextActive = 1'b0;
        pos_x = 11'd0; pos_y = 10'd0; pos_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", pixel, 6'd0);
        chk("rst_ready", pos_ready, 1'b1);
        chk("rst_tick", frame_tick, 1'b0);
        @(negedge clk); rst = 1'b1;

        // No request yet: background only, apply event without tick.
        step(11'd10, 10'd10, 1'b1);   chk("bg_10_10", pixel, BG);
        step(11'd799, 10'd599, 1'b1); chk("bg_799_599", pixel, BG);
        step(11'd0, 10'd600, 1'b0);   chk("no_tick", frame_tick, 1'b0);

        // Sprite at (100,50): not visible until the apply event.
        send_req(11'd100, 10'd50, 1'b1);
        chk("pend_ready", pos_ready, 1'b0);
        step(11'd100, 10'd50, 1'b1);  chk("no_tear", pixel, BG);
        step(11'd0, 10'd600, 1'b0);
        chk("apply_tick", frame_tick, 1'b1);
        chk("apply_ready", pos_ready, 1'b1);
        step(11'd1, 10'd600, 1'b0);   chk("tick_one", frame_tick, 1'b0);

        step(11'd99, 10'd50, 1'b1);   chk("h99", pixel, BG);
        present(11'd100, 10'd50, 1'b1);
        #1 chk("addr_100_50", spr_addr, 10'd0);
        tick();                        chk("h100", pixel, 6'd1);
        step(11'd131, 10'd50, 1'b1);  chk("h131", pixel, 6'd32);
        step(11'd132, 10'd50, 1'b1);  chk("h132", pixel, BG);
        present(11'd131, 10'd81, 1'b1);
        #1 chk("addr_last", spr_addr, 10'd1023);
        tick();
        step(11'd100, 10'd81, 1'b1);  chk("v81", pixel, 6'd33);
        step(11'd100, 10'd82, 1'b1);  chk("v82", pixel, BG);

        // Transparency with sprite at the origin.
        send_req(11'd0, 10'd0, 1'b1);
        step(11'd0, 10'd600, 1'b0);   chk("tick_origin", frame_tick, 1'b1);
        step(11'd0, 10'd0, 1'b1);     chk("org_0", pixel, 6'd1);
        step(11'd4, 10'd0, 1'b1);     chk("org_4", pixel, 6'd5);
        step(11'd5, 10'd0, 1'b1);     chk("key_5", pixel, BG);

        // Clipping at the bottom-right corner.
        send_req(11'd790, 10'd590, 1'b1);
        step(11'd0, 10'd600, 1'b0);   chk("tick_edge", frame_tick, 1'b1);
        step(11'd790, 10'd590, 1'b1); chk("edge_790", pixel, 6'd1);
        step(11'd799, 10'd590, 1'b1); chk("edge_799", pixel, 6'd10);
        step(11'd800, 10'd590, 1'b0); chk("edge_800", pixel, 6'd0);
        step(11'd1039, 10'd590, 1'b0); chk("edge_1039", pixel, 6'd0);
        step(11'd0, 10'd591, 1'b1);   chk("no_wrap", pixel, BG);
        step(11'd790, 10'd599, 1'b1); chk("edge_v599", pixel, 6'd33);
        present(11'd799, 10'd599, 1'b1);
        #1 chk("addr_corner", spr_addr, 10'd297);
        tick();                        chk("corner", pixel, 6'd42);

        // Back-pressure: second request held until the first is applied.
        send_req(11'd200, 10'd100, 1'b1);
        chk("bp_pend", pos_ready, 1'b0);
        @(negedge clk);
        pos_x = 11'd300; pos_y = 10'd150; pos_valid = 1'b1;
        #1 chk("bp_ready_lo", pos_ready, 1'b0);
        step(11'd0, 10'd600, 1'b0);
        chk("bp_tick", frame_tick, 1'b1);
        chk("bp_ready_hi", pos_ready, 1'b1);
        step(11'd1, 10'd600, 1'b0);
        pos_valid = 1'b0;
        chk("bp_accept", pos_ready, 1'b0);
        step(11'd199, 10'd100, 1'b1); chk("bp_h199", pixel, BG);
        step(11'd200, 10'd100, 1'b1); chk("bp_first", pixel, 6'd1);
        step(11'd0, 10'd600, 1'b0);   chk("bp_tick2", frame_tick, 1'b1);
        step(11'd200, 10'd100, 1'b1); chk("bp_old_gone", pixel, BG);
        step(11'd299, 10'd150, 1'b1); chk("bp_h299", pixel, BG);
        step(11'd300, 10'd150, 1'b1); chk("bp_second", pixel, 6'd1);

        // en gating: hold for 10 cycles mid-line, then resume.
        @(negedge clk);
        nextH = 11'd301; en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("gate_pixel", pixel, 6'd1);
        chk("gate_ready", pos_ready, 1'b1);
        @(negedge clk); en = 1'b1;
        tick();                        chk("gate_301", pixel, 6'd2);
        step(11'd302, 10'd150, 1'b1); chk("gate_302", pixel, 6'd3);

        // Reset mid-frame drops a pending request.
        send_req(11'd10, 10'd10, 1'b1);
        chk("mid_pend", pos_ready, 1'b0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("mid_rst_ready", pos_ready, 1'b1);
        chk("mid_rst_pixel", pixel, 6'd0);
        @(negedge clk); rst = 1'b1;
        step(11'd0, 10'd600, 1'b0);   chk("mid_no_tick", frame_tick, 1'b0);
        step(11'd10, 10'd10, 1'b1);   chk("mid_bg", pixel, BG);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
